// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: sub-step state encoding, default sideband
// REQ/RSP code pairs and the default watchdog length.
package mbtrain_pkg;

    // Sub-step initiator states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_REQ = 3'd1,
        ST_ACTION    = 3'd2,
        ST_END_REQ   = 3'd3,
        ST_DONE      = 3'd4,
        ST_TOUT      = 3'd5
    } substep_state_e;

    // Default sideband codes, one REQ/RSP pair per open and close of a sub-step
    localparam logic [3:0] RXCAL_START_REQ   = 4'h1;
    localparam logic [3:0] RXCAL_START_RSP   = 4'h2;
    localparam logic [3:0] RXCAL_END_REQ     = 4'h3;
    localparam logic [3:0] RXCAL_END_RSP     = 4'h4;
    localparam logic [3:0] VALTRAIN_START_REQ = 4'h5;
    localparam logic [3:0] VALTRAIN_START_RSP = 4'h6;
    localparam logic [3:0] VALTRAIN_END_REQ   = 4'h7;
    localparam logic [3:0] VALTRAIN_END_RSP   = 4'h8;
    localparam logic [3:0] DATATRAIN_START_REQ = 4'h9;
    localparam logic [3:0] DATATRAIN_START_RSP = 4'hA;
    localparam logic [3:0] DATATRAIN_END_REQ   = 4'hB;
    localparam logic [3:0] DATATRAIN_END_RSP   = 4'hC;

    // 8 ms at the 100 MHz reference clock
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 800000;

endpackage

// File: rtl/ltsm_timeout_counter.sv
// Saturating cycle counter shared by the LTSM blocks. o_expired is high
// while the count sits at CYCLES-1; it holds there until i_clear.
// CYCLES=0 disables the counter (o_expired stays low).
module ltsm_timeout_counter #(
    parameter int unsigned CYCLES = 800000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((CYCLES == 0) ? 0 : CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear has priority; counting stops at the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mbtrain_substep_tx.sv
// Generic initiator for one MBTRAIN sub-step handshake:
// start req -> start rsp -> local action -> end req -> end rsp -> ack.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for i_en
// START_REQ | start request sent, waiting for start response
// ACTION    | local action running (timed or i_action_done)
// END_REQ   | end request sent, waiting for end response
// DONE      | sub-step completed, ack held until i_en drops
// TOUT      | watchdog fired, ack+timeout held until i_en drops
module mbtrain_substep_tx
    import mbtrain_pkg::*;
#(
    parameter int unsigned      MSG_W           = 4,
    parameter logic [MSG_W-1:0] START_REQ_MSG   = MSG_W'(RXCAL_START_REQ),
    parameter logic [MSG_W-1:0] START_RSP_MSG   = MSG_W'(RXCAL_START_RSP),
    parameter logic [MSG_W-1:0] END_REQ_MSG     = MSG_W'(RXCAL_END_REQ),
    parameter logic [MSG_W-1:0] END_RSP_MSG     = MSG_W'(RXCAL_END_RSP),
    parameter bit               USE_ACTION_DONE = 1'b1,
    parameter int unsigned      ACTION_CYCLES   = 1,
    parameter int unsigned      TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [MSG_W-1:0] i_decoded_sideband_message,
    input  logic             i_sideband_valid,
    input  logic             i_busy_negedge_detected,
    input  logic             i_valid_rx,
    input  logic             i_action_done,
    output logic [MSG_W-1:0] o_sideband_message,
    output logic             o_valid_tx,
    output logic             o_action_start,
    output logic             o_test_ack,
    output logic             o_timeout
);

    localparam int unsigned ACT_LEN = (ACTION_CYCLES == 0) ? 1 : ACTION_CYCLES;

    substep_state_e   state_q;
    logic [MSG_W-1:0] msg_q;
    logic             valid_q;
    logic             astart_q;
    logic             ack_q;
    logic             tout_q;

    logic in_step;
    logic wdog_expired;
    logic act_expired;
    logic start_rsp;
    logic end_rsp;
    logic action_exit;
    logic step_exit;

    assign in_step = (state_q == ST_START_REQ) || (state_q == ST_ACTION) ||
                     (state_q == ST_END_REQ);

    // Watchdog spans the whole handshake, from leaving IDLE to completion
    ltsm_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (state_q == ST_IDLE),
        .i_run     (in_step),
        .o_expired (wdog_expired)
    );

    // Action length timer; rearmed whenever the FSM is outside ACTION
    ltsm_timeout_counter #(
        .CYCLES (ACT_LEN)
    ) u_act_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (state_q != ST_ACTION),
        .i_run     (state_q == ST_ACTION),
        .o_expired (act_expired)
    );

    // Exit conditions for the three active states
    always_comb begin
        start_rsp   = i_sideband_valid && (i_decoded_sideband_message == START_RSP_MSG);
        end_rsp     = i_sideband_valid && (i_decoded_sideband_message == END_RSP_MSG);
        action_exit = USE_ACTION_DONE ? i_action_done : act_expired;
        step_exit   = ((state_q == ST_START_REQ) && start_rsp)   ||
                      ((state_q == ST_ACTION)    && action_exit) ||
                      ((state_q == ST_END_REQ)   && end_rsp);
    end

    // Sub-step FSM with registered outputs; abort > exit > watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            msg_q    <= '0;
            valid_q  <= 1'b0;
            astart_q <= 1'b0;
            ack_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            astart_q <= 1'b0;
            // TX mux took the message; transitions below re-arm and win
            if (i_busy_negedge_detected && !i_valid_rx) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_en) begin
                        state_q <= ST_START_REQ;
                        msg_q   <= START_REQ_MSG;
                        valid_q <= 1'b1;
                    end
                end
                ST_START_REQ, ST_ACTION, ST_END_REQ: begin
                    if (!i_en) begin
                        state_q <= ST_IDLE;
                        msg_q   <= '0;
                        valid_q <= 1'b0;
                        ack_q   <= 1'b0;
                        tout_q  <= 1'b0;
                    end else if (step_exit) begin
                        case (state_q)
                            ST_START_REQ: begin
                                state_q  <= ST_ACTION;
                                astart_q <= 1'b1;
                            end
                            ST_ACTION: begin
                                state_q <= ST_END_REQ;
                                msg_q   <= END_REQ_MSG;
                                valid_q <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_DONE;
                                msg_q   <= '0;
                                ack_q   <= 1'b1;
                            end
                        endcase
                    end else if (wdog_expired) begin
                        state_q <= ST_TOUT;
                        msg_q   <= '0;
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        tout_q  <= 1'b1;
                    end
                end
                ST_DONE, ST_TOUT: begin
                    if (!i_en) begin
                        state_q <= ST_IDLE;
                        msg_q   <= '0;
                        ack_q   <= 1'b0;
                        tout_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sideband_message = msg_q;
    assign o_valid_tx         = valid_q;
    assign o_action_start     = astart_q;
    assign o_test_ack         = ack_q;
    assign o_timeout          = tout_q;

endmodule

// File: tb/tb_mbtrain_substep_tx.sv
// Bench for mbtrain_substep_tx: timed action of 3 cycles, 20-cycle watchdog.
// A phase/elapsed-time model predicts every output each cycle; directed
// literal checks pin the model at the interesting points.
module tb_mbtrain_substep_tx;

    localparam int ACT_N = 3;
    localparam int TO_N  = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] sbm   = 4'h0;
    logic       sbv   = 1'b0;
    logic       busy  = 1'b0;
    logic       vrx   = 1'b0;
    logic       adone = 1'b0;

    logic [3:0] msg;
    logic       vtx, astart, ack, tout;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model: phase 0 idle, 1 wait start rsp, 2 action, 3 wait end rsp, 4 finished
    int         m_phase;
    int         m_elapsed;
    int         m_act;
    logic [3:0] e_msg;
    logic       e_vtx, e_as, e_ack, e_tout;

    always #5 clk = ~clk;

    mbtrain_substep_tx #(
        .MSG_W           (4),
        .START_REQ_MSG   (4'h1),
        .START_RSP_MSG   (4'h2),
        .END_REQ_MSG     (4'h3),
        .END_RSP_MSG     (4'h4),
        .USE_ACTION_DONE (1'b0),
        .ACTION_CYCLES   (ACT_N),
        .TIMEOUT_CYCLES  (TO_N)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (en),
        .i_decoded_sideband_message (sbm),
        .i_sideband_valid           (sbv),
        .i_busy_negedge_detected    (busy),
        .i_valid_rx                 (vrx),
        .i_action_done              (adone),
        .o_sideband_message         (msg),
        .o_valid_tx                 (vtx),
        .o_action_start             (astart),
        .o_test_ack                 (ack),
        .o_timeout                  (tout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_act     = 0;
        e_msg     = 4'h0;
        e_vtx     = 1'b0;
        e_as      = 1'b0;
        e_ack     = 1'b0;
        e_tout    = 1'b0;
    endtask

    // One clock edge of the handshake rules, using the inputs held at the edge
    task automatic model_step();
        logic nv;
        bit   moved;
        moved = 1'b0;
        nv    = (busy && !vrx) ? 1'b0 : e_vtx;
        e_as  = 1'b0;
        if (m_phase == 0) begin
            if (en) begin
                m_phase   = 1;
                m_elapsed = 0;
                e_msg     = 4'h1;
                nv        = 1'b1;
            end
        end else if (m_phase <= 3) begin
            if (!en) begin
                m_phase = 0;
                e_msg   = 4'h0;
                nv      = 1'b0;
                e_ack   = 1'b0;
                e_tout  = 1'b0;
            end else begin
                m_elapsed++;
                if (m_phase == 1 && sbv && sbm == 4'h2) begin
                    m_phase = 2;
                    m_act   = 0;
                    e_as    = 1'b1;
                    moved   = 1'b1;
                end else if (m_phase == 2) begin
                    m_act++;
                    if (m_act == ACT_N) begin
                        m_phase = 3;
                        e_msg   = 4'h3;
                        nv      = 1'b1;
                        moved   = 1'b1;
                    end
                end else if (m_phase == 3 && sbv && sbm == 4'h4) begin
                    m_phase = 4;
                    e_ack   = 1'b1;
                    e_msg   = 4'h0;
                    moved   = 1'b1;
                end
                if (!moved && m_elapsed >= TO_N) begin
                    m_phase = 4;
                    e_tout  = 1'b1;
                    e_ack   = 1'b1;
                    e_msg   = 4'h0;
                    nv      = 1'b0;
                end
            end
        end else begin
            if (!en) begin
                m_phase = 0;
                e_ack   = 1'b0;
                e_tout  = 1'b0;
                e_msg   = 4'h0;
            end
        end
        e_vtx = nv;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_msg", 32'(msg), 32'(e_msg));
            chk("cmp_valid_tx", 32'(vtx), 32'(e_vtx));
            chk("cmp_action_start", 32'(astart), 32'(e_as));
            chk("cmp_test_ack", 32'(ack), 32'(e_ack));
            chk("cmp_timeout", 32'(tout), 32'(e_tout));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running want finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_msg", 32'(msg), 0);
        chk("rst_valid", 32'(vtx), 0);
        chk("rst_astart", 32'(astart), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tout", 32'(tout), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // happy path with valid handshake and ignored responses
        en = 1'b1; tick();
        chk("hp_msg_start", 32'(msg), 32'h1);
        chk("hp_valid_set", 32'(vtx), 1);
        busy = 1'b1; vrx = 1'b1; tick();
        chk("hp_valid_rx_owns", 32'(vtx), 1);
        vrx = 1'b0; tick();
        chk("hp_valid_clear", 32'(vtx), 0);
        busy = 1'b0; tick();
        sbm = 4'h2; sbv = 1'b1; tick();
        chk("hp_astart_pulse", 32'(astart), 1);
        sbm = 4'h0; sbv = 1'b0; tick();
        chk("hp_astart_once", 32'(astart), 0);
        chk("hp_msg_hold", 32'(msg), 32'h1);
        tick();
        chk("hp_msg_act2", 32'(msg), 32'h1);
        busy = 1'b1; tick();
        chk("hp_msg_end_req", 32'(msg), 32'h3);
        chk("hp_set_wins", 32'(vtx), 1);
        busy = 1'b0;
        sbm = 4'h4; sbv = 1'b0; tick();
        chk("hp_unqualified", 32'(ack), 0);
        chk("hp_unqualified_msg", 32'(msg), 32'h3);
        sbm = 4'h2; sbv = 1'b1; tick();
        chk("hp_start_rsp_in_end", 32'(ack), 0);
        sbv = 1'b0; busy = 1'b1; tick();
        busy = 1'b0;
        chk("hp_valid_clear2", 32'(vtx), 0);
        sbm = 4'h4; sbv = 1'b1; tick();
        chk("hp_ack", 32'(ack), 1);
        chk("hp_msg_zero", 32'(msg), 0);
        chk("hp_no_tout", 32'(tout), 0);
        sbm = 4'h0; sbv = 1'b0; tick(); tick();
        chk("hp_ack_hold", 32'(ack), 1);
        en = 1'b0; tick();
        chk("hp_ack_clear", 32'(ack), 0);
        tick();

        // timeout with no response
        en = 1'b1; tick();
        for (int i = 0; i < TO_N - 1; i++) tick();
        chk("to_not_yet", 32'(tout), 0);
        tick();
        chk("to_timeout", 32'(tout), 1);
        chk("to_ack", 32'(ack), 1);
        chk("to_valid_low", 32'(vtx), 0);
        en = 1'b0; tick();
        chk("to_tout_clear", 32'(tout), 0);
        chk("to_ack_clear", 32'(ack), 0);
        tick();

        // end response lands on the expiry cycle
        en = 1'b1; tick();
        tick();
        sbm = 4'h2; sbv = 1'b1; tick();
        sbm = 4'h0; sbv = 1'b0;
        repeat (ACT_N) tick();
        busy = 1'b1; tick();
        busy = 1'b0;
        repeat (13) tick();
        sbm = 4'h4; sbv = 1'b1; tick();
        chk("exp_rsp_ack", 32'(ack), 1);
        chk("exp_rsp_no_tout", 32'(tout), 0);
        sbm = 4'h0; sbv = 1'b0;
        en = 1'b0; tick();
        tick();

        // abort during ACTION with valid still high
        en = 1'b1; tick();
        sbm = 4'h2; sbv = 1'b1; tick();
        sbm = 4'h0; sbv = 1'b0;
        chk("ab_valid_high", 32'(vtx), 1);
        en = 1'b0; tick();
        chk("ab_msg", 32'(msg), 0);
        chk("ab_valid", 32'(vtx), 0);
        chk("ab_ack", 32'(ack), 0);
        en = 1'b1; tick();
        chk("ab_restart_msg", 32'(msg), 32'h1);
        chk("ab_restart_valid", 32'(vtx), 1);
        en = 1'b0; tick();
        tick();

        // asynchronous reset while in END_REQ
        en = 1'b1; tick();
        sbm = 4'h2; sbv = 1'b1; tick();
        sbm = 4'h0; sbv = 1'b0;
        repeat (ACT_N) tick();
        chk("ar_in_end_req", 32'(msg), 32'h3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_msg", 32'(msg), 0);
        chk("ar_valid", 32'(vtx), 0);
        chk("ar_ack", 32'(ack), 0);
        en = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1; tick();
        chk("ar_idle", 32'(msg), 0);
        en = 1'b1; tick();
        chk("ar_restart_msg", 32'(msg), 32'h1);
        en = 1'b0; tick();
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbtrain_substep_tx.md
Name: mbtrain_substep_tx

Overview:
- Generic, parametrised initiator for one MBTRAIN sub-step handshake: start request, then start response, then local action, then end request, then end response, then ack.
- It generalises the fixed-code RX-calibration initiator:
  - message codes and widths are configurable;
  - the action phase is timed or handshaked;
  - a timeout with error flag is added;
  - end-response matching is qualified with the valid strobe;
  - the sub-step aborts cleanly when enable drops.
- It sits between the MBTRAIN sequencer (i_en / o_test_ack) and the sideband message mux.

Parameters:
- MSG_W, 4, sideband message-code width.
- START_REQ_MSG, 4'h1, code sent to open the sub-step.
- START_RSP_MSG, 4'h2, partner code that permits the action.
- END_REQ_MSG, 4'h3, code sent to close the sub-step.
- END_RSP_MSG, 4'h4, partner code that completes the sub-step.
- USE_ACTION_DONE, 1, 1 means the action ends on i_action_done; 0 means it ends after ACTION_CYCLES.
- ACTION_CYCLES, 1, fixed action length in clocks (minimum 1), used only when USE_ACTION_DONE=0.
- TIMEOUT_CYCLES, 800000, watchdog from leaving IDLE until completion; 0 disables it.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- i_en, input, 1, sub-step enable from the sequencer; level-held for the whole sub-step.
- i_decoded_sideband_message, input, MSG_W, decoded received sideband code.
- i_sideband_valid, input, 1, qualifies i_decoded_sideband_message.
- i_busy_negedge_detected, input, 1, sideband TX finished the previous message.
- i_valid_rx, input, 1, RX-side responder currently owns the TX mux.
- i_action_done, input, 1, local action complete (pulse or level).
- o_sideband_message, output, MSG_W, code to transmit.
- o_valid_tx, output, 1, request for the sideband mux to send o_sideband_message.
- o_action_start, output, 1, one-cycle pulse on entering ACTION.
- o_test_ack, output, 1, sub-step finished (success or timeout).
- o_timeout, output, 1, sub-step ended by the watchdog.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, START_REQ, ACTION, END_REQ, DONE, TOUT. All outputs are registered.
- IDLE:
  - When i_en=1, go to START_REQ.
  - On the same edge: o_sideband_message<=START_REQ_MSG and o_valid_tx<=1.
- START_REQ:
  - When i_sideband_valid && message==START_RSP_MSG, go to ACTION.
  - o_action_start is high during the first ACTION cycle only.
  - o_sideband_message holds its value.
- ACTION:
  - USE_ACTION_DONE=1: leave when i_action_done=1. i_action_done is sampled from the first ACTION cycle onward.
  - USE_ACTION_DONE=0: leave after exactly ACTION_CYCLES cycles in ACTION.
  - On exit go to END_REQ, with o_sideband_message<=END_REQ_MSG and o_valid_tx<=1.
- END_REQ:
  - When i_sideband_valid && message==END_RSP_MSG, go to DONE.
  - On that edge: o_test_ack<=1 and o_sideband_message<=0.
- DONE and TOUT: hold the outputs until i_en=0, then go to IDLE and clear o_test_ack, o_timeout and o_sideband_message.
- Valid handling:
  - o_valid_tx is set on each transition into START_REQ or END_REQ.
  - It is cleared when i_busy_negedge_detected && !i_valid_rx.
  - If set and clear fall on the same cycle, set wins.
  - A response may be accepted while o_valid_tx is still 1; valid still clears by the busy rule.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter is zeroed in IDLE and increments in START_REQ, ACTION and END_REQ.
  - When the count reaches TIMEOUT_CYCLES-1 with no exit that cycle, go to TOUT.
  - On that edge: o_timeout<=1, o_test_ack<=1, o_valid_tx<=0, o_sideband_message<=0.
  - If a valid response and timeout expiry fall on the same cycle, the response wins.
- Abort: i_en=0 in START_REQ, ACTION or END_REQ sends the FSM to IDLE next edge and clears every output, o_valid_tx included. Abort has priority over a response and over timeout.
- Ignored inputs:
  - Non-matching codes, and codes with i_sideband_valid=0, are ignored in every state.
  - A START_RSP_MSG code received in END_REQ is ignored.
- Re-entry: after DONE/TOUT → IDLE, the next i_en rise starts a fresh sub-step with the counters cleared.

Decomposition:
- Shared package mbtrain_pkg holds:
  - the state encoding localparams;
  - the default sideband code constants (REQ/RSP pairs for each MBTRAIN sub-step);
  - the default timeout value (8 ms at the reference clock).
- One sub-module, ltsm_timeout_counter:
  - parameters: CYCLES; width derived with $clog2;
  - ports: clk, rst_n, i_clear, i_run, o_expired.
  - It is reused by other LTSM blocks.

Test Plan:
- Happy path, USE_ACTION_DONE=0, ACTION_CYCLES=3:
  - Stimulus: i_en=1; START_RSP (valid) at cycle 5; END_RSP (valid) at cycle 12.
  - Response: message 1, then 3 exactly 3 cycles after the ACTION entry, then 0 with o_test_ack=1; o_action_start pulses once; o_timeout=0.
- Valid handshake:
  - Stimulus: busy negedge with i_valid_rx=1, then with i_valid_rx=0.
  - Response: o_valid_tx stays 1, then clears.
  - Stimulus: busy negedge on the same cycle as END_REQ entry.
  - Response: o_valid_tx stays 1.
- Unqualified response:
  - Stimulus: END_RSP code with i_sideband_valid=0.
  - Response: stays in END_REQ; advances only when valid=1.
  - Stimulus: code 4'h2 in END_REQ.
  - Response: ignored.
- Timeout, TIMEOUT_CYCLES=20:
  - Stimulus: no response.
  - Response: 20 cycles after leaving IDLE, o_timeout=1 and o_test_ack=1 with valid=0; both clear one cycle after i_en=0.
  - Stimulus: response on the expiry cycle.
  - Response: success path, o_timeout=0.
- Abort:
  - Stimulus: i_en=0 while in ACTION with o_valid_tx=1.
  - Response: next cycle IDLE, all outputs 0; a re-enable restarts with message 1.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously in END_REQ.
  - Response: outputs 0 immediately, without waiting for a clk edge; after release, IDLE.
